serving_arbiter_rr: RTL and testbench
=====================================

SERVING_ARBITER_RR -- requirements
Module: serving_arbiter_rr

Interface
REQ-001 SHALL have parameter NM, default 2, meaning number of Wishbone masters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum BUSY cycles without slave ack (1..65535).
REQ-003 SHALL have port i_clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port i_wb_m_adr, input, NM*32, master addresses; master k occupies bits [32k+31:32k].
REQ-006 SHALL have port i_wb_m_dat, input, NM*32, master write data, same packing.
REQ-007 SHALL have port i_wb_m_sel, input, NM*4, master byte selects, same packing.
REQ-008 SHALL have ports i_wb_m_we and i_wb_m_stb, input, NM each, per-master write enable and strobe.
REQ-009 SHALL have port o_wb_m_rdt, output, 32, read data shared by all masters; valid only with that master's ack.
REQ-010 SHALL have port o_wb_m_ack, output, NM, per-master ack.
REQ-011 SHALL have ports o_wb_s_adr (32), o_wb_s_dat (32), o_wb_s_sel (4), o_wb_s_we (1), o_wb_s_stb (1), outputs to the shared slave.
REQ-012 SHALL have ports i_wb_s_rdt (32) and i_wb_s_ack (1), inputs from the slave.
REQ-013 SHALL have port o_grant, output, NM, one-hot index of the master currently owning the slave; all-zero in IDLE.
REQ-014 SHALL have port o_timeout, output, 1, one-cycle pulse on a timeout abort.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-016 In IDLE with any i_wb_m_stb high, SHALL register a grant to the first requesting master searching upward from (last+1) mod NM, wrapping, and enter BUSY next cycle.
REQ-017 "last" SHALL be the most recently granted master; reset value NM-1, so master 0 has first priority after reset.
REQ-018 In BUSY, o_wb_s_adr/dat/sel/we SHALL equal the granted master's fields, and o_wb_s_stb SHALL equal the granted master's stb; in IDLE all slave outputs SHALL be 0.
REQ-019 Latency: master stb rising in IDLE at cycle N SHALL produce o_wb_s_stb at cycle N+1 (one registered arbitration cycle).
REQ-020 In BUSY, i_wb_s_ack SHALL pass combinationally to o_wb_m_ack of the granted master only, o_wb_m_rdt = i_wb_s_rdt, and the FSM SHALL return to IDLE next cycle.
REQ-021 Grant SHALL be held for the whole transaction; requests from other masters SHALL not preempt.
REQ-022 If the granted master drops stb in BUSY without an ack, FSM SHALL return to IDLE next cycle with no ack issued.
REQ-023 Slave ack in IDLE SHALL be ignored; o_wb_m_ack SHALL be all-zero in IDLE.
REQ-024 After a completion, at least one IDLE cycle SHALL separate consecutive grants; a master re-requesting immediately SHALL lose to any other requester.
REQ-025 o_wb_m_rdt SHALL be 0 whenever no ack is asserted.

Reset
REQ-026 On i_rst_n low, SHALL immediately force IDLE, last = NM-1, o_grant = 0, timeout counter = 0, all acks, o_wb_s_stb and o_timeout = 0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack; the first grant after release SHALL follow REQ-017.

Configuration
REQ-028 With macro SERVING_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entering BUSY, increment each BUSY cycle without slave ack, and on reaching TIMEOUT SHALL assert the granted master's ack with o_wb_m_rdt = 32'h0, pulse o_timeout, force o_wb_s_stb low that cycle, and return to IDLE.
REQ-029 A slave ack arriving in the same cycle as the count reaching TIMEOUT SHALL win: normal completion, no o_timeout.
REQ-030 Without SERVING_ARB_TIMEOUT_EN, no counter SHALL exist, o_timeout SHALL be tied 0, and BUSY SHALL wait indefinitely for ack.

Verification
REQ-031 NM=2: master 0 read adr 0x100, slave acks after 3 cycles with rdt 0xCAFE0001 -> o_wb_s_stb one cycle after m0 stb, o_wb_m_ack=2'b01 with rdt 0xCAFE0001, IDLE next cycle.
REQ-032 NM=3: all three stb held continuously, slave acks each after 1 cycle -> grant order 0,1,2,0, each separated by one IDLE cycle.
REQ-033 NM=2: m1 write adr 0x2000 dat 0x12345678 sel 4'b0011 -> slave sees exactly these fields with we=1; m0 request during it is not granted until after ack.
REQ-034 Macro defined, TIMEOUT=4, slave never acks -> after 4 BUSY cycles m0 acked with rdt 0, o_timeout pulses one cycle; ack and timeout same cycle -> normal ack, no pulse.
REQ-035 i_rst_n pulled low in BUSY before ack -> o_grant=0, o_wb_s_stb=0 immediately, no ack; after release with both requesting, master 0 granted first.

Source files
------------

// File: rtl/serving_arbiter_rr.sv
// Round-robin arbiter that lets NM Wishbone masters share one slave, one transaction at a time.
// Optional BUSY watchdog is compiled in when SERVING_ARB_TIMEOUT_EN is defined.
module serving_arbiter_rr #(
   parameter int NM      = 2,
   parameter int TIMEOUT = 255
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NM*32-1:0]   i_wb_m_adr,
   input  logic [NM*32-1:0]   i_wb_m_dat,
   input  logic [NM*4-1:0]    i_wb_m_sel,
   input  logic [NM-1:0]      i_wb_m_we,
   input  logic [NM-1:0]      i_wb_m_stb,
   output logic [31:0]        o_wb_m_rdt,
   output logic [NM-1:0]      o_wb_m_ack,
   output logic [31:0]        o_wb_s_adr,
   output logic [31:0]        o_wb_s_dat,
   output logic [3:0]         o_wb_s_sel,
   output logic               o_wb_s_we,
   output logic               o_wb_s_stb,
   input  logic [31:0]        i_wb_s_rdt,
   input  logic               i_wb_s_ack,
   output logic [NM-1:0]      o_grant,
   output logic               o_timeout
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam logic [NM-1:0] ONE = {{(NM-1){1'b0}}, 1'b1};

   if (NM < 2 || NM > 8) begin : g_bad_nm
      $error("serving_arbiter_rr: NM out of range");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("serving_arbiter_rr: TIMEOUT out of range");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [NM-1:0]   grant_q, grant_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   cand;
   logic            found;
   logic            busy;
   logic            cur_stb;
   logic            ack_fire;
   logic            to_fire;

   assign busy     = (state_q == BUSY);
   assign cur_stb  = i_wb_m_stb[last_q];
   assign ack_fire = busy & i_wb_s_ack;

`ifdef SERVING_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;

   // A slave ack in the limit cycle takes precedence over the abort.
   assign to_fire = busy & cur_stb & ~i_wb_s_ack & (cnt_q == 16'(TIMEOUT));

   always_comb begin
      cnt_d = '0;
      if (busy && !i_wb_s_ack) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign to_fire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      found   = 1'b0;
      cand    = '0;
      case (state_q)
         IDLE: begin
            // Search starts just past the previous owner, so it naturally goes last.
            for (int i = 1; i <= NM; i++) begin
               cand = IW'((int'(last_q) + i) % NM);
               if (!found && i_wb_m_stb[cand]) begin
                  found  = 1'b1;
                  last_d = cand;
               end
            end
            if (found) begin
               state_d = BUSY;
               grant_d = ONE << last_d;
            end
         end
         BUSY: begin
            if (ack_fire || !cur_stb || to_fire) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(NM - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign o_grant    = grant_q;
   assign o_wb_m_ack = grant_q & {NM{ack_fire | to_fire}};
   assign o_wb_m_rdt = ack_fire ? i_wb_s_rdt : 32'h0;
   assign o_timeout  = to_fire;

   assign o_wb_s_adr = busy ? i_wb_m_adr[32*last_q +: 32] : 32'h0;
   assign o_wb_s_dat = busy ? i_wb_m_dat[32*last_q +: 32] : 32'h0;
   assign o_wb_s_sel = busy ? i_wb_m_sel[4*last_q +: 4]   : 4'h0;
   assign o_wb_s_we  = busy & i_wb_m_we[last_q];
   assign o_wb_s_stb = busy & cur_stb & ~to_fire;

endmodule

// File: tb/tb_serving_arbiter_rr.sv
// Directed bench for serving_arbiter_rr: a 2-master instance and a 3-master instance on one clock.
module tb_serving_arbiter_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_cmp = 0;
   int          n_err = 0;

   logic [63:0] m_adr_a, m_dat_a;
   logic [7:0]  m_sel_a;
   logic [1:0]  m_we_a, m_stb_a, ack_a, grant_a;
   logic [31:0] rdt_a, s_adr_a, s_dat_a, s_rdt_a;
   logic [3:0]  s_sel_a;
   logic        s_we_a, s_stb_a, s_ack_a, to_a;

   logic [95:0] m_adr_b, m_dat_b;
   logic [11:0] m_sel_b;
   logic [2:0]  m_we_b, m_stb_b, ack_b, grant_b;
   logic [31:0] rdt_b, s_adr_b, s_dat_b, s_rdt_b;
   logic [3:0]  s_sel_b;
   logic        s_we_b, s_stb_b, s_ack_b, to_b;

   always #5 clk = ~clk;

   serving_arbiter_rr #(.NM(2), .TIMEOUT(4)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wb_m_adr(m_adr_a), .i_wb_m_dat(m_dat_a), .i_wb_m_sel(m_sel_a),
      .i_wb_m_we(m_we_a), .i_wb_m_stb(m_stb_a),
      .o_wb_m_rdt(rdt_a), .o_wb_m_ack(ack_a),
      .o_wb_s_adr(s_adr_a), .o_wb_s_dat(s_dat_a), .o_wb_s_sel(s_sel_a),
      .o_wb_s_we(s_we_a), .o_wb_s_stb(s_stb_a),
      .i_wb_s_rdt(s_rdt_a), .i_wb_s_ack(s_ack_a),
      .o_grant(grant_a), .o_timeout(to_a)
   );

   serving_arbiter_rr #(.NM(3), .TIMEOUT(4)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wb_m_adr(m_adr_b), .i_wb_m_dat(m_dat_b), .i_wb_m_sel(m_sel_b),
      .i_wb_m_we(m_we_b), .i_wb_m_stb(m_stb_b),
      .o_wb_m_rdt(rdt_b), .o_wb_m_ack(ack_b),
      .o_wb_s_adr(s_adr_b), .o_wb_s_dat(s_dat_b), .o_wb_s_sel(s_sel_b),
      .o_wb_s_we(s_we_b), .o_wb_s_stb(s_stb_b),
      .i_wb_s_rdt(s_rdt_b), .i_wb_s_ack(s_ack_b),
      .o_grant(grant_b), .o_timeout(to_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow one unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic [2:0] exp_g [8];
      exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

      rst_n = 1'b0;
      m_adr_a = '0; m_dat_a = '0; m_sel_a = '0; m_we_a = '0; m_stb_a = '0;
      s_rdt_a = '0; s_ack_a = 1'b0;
      m_adr_b = {32'h0000_0320, 32'h0000_0310, 32'h0000_0300};
      m_dat_b = '0; m_sel_b = '0; m_we_b = '0; m_stb_b = '0;
      s_rdt_b = 32'h0000_00B0; s_ack_b = 1'b0;

      #12;
      chk("rst_grant", grant_a, 2'b00);
      chk("rst_s_stb", s_stb_a, 1'b0);
      chk("rst_ack", ack_a, 2'b00);
      chk("rst_timeout", to_a, 1'b0);
      chk("rst_rdt", rdt_a, 32'h0);
      rst_n = 1'b1;

      // Master 0 read, slave acks in the third BUSY cycle.
      step();
      m_adr_a[31:0] = 32'h0000_0100; m_stb_a = 2'b01;
      #1;
      chk("rd_idle_grant", grant_a, 2'b00);
      chk("rd_idle_s_stb", s_stb_a, 1'b0);
      step(); #1;
      chk("rd_s_stb", s_stb_a, 1'b1);
      chk("rd_s_adr", s_adr_a, 32'h0000_0100);
      chk("rd_s_we", s_we_a, 1'b0);
      chk("rd_grant", grant_a, 2'b01);
      chk("rd_no_ack", ack_a, 2'b00);
      step(); #1;
      chk("rd_wait_ack", ack_a, 2'b00);
      step();
      s_ack_a = 1'b1; s_rdt_a = 32'hCAFE_0001;
      #1;
      chk("rd_ack", ack_a, 2'b01);
      chk("rd_rdt", rdt_a, 32'hCAFE_0001);
      step();
      m_stb_a = 2'b00;
      #1;
      chk("rd_back_idle", grant_a, 2'b00);
      chk("idle_ack_ignored", ack_a, 2'b00);
      chk("idle_rdt_zero", rdt_a, 32'h0);
      chk("idle_s_stb", s_stb_a, 1'b0);
      s_ack_a = 1'b0; s_rdt_a = 32'h0;

      // Master 1 write; master 0 asks during it and must wait.
      step();
      m_adr_a[63:32] = 32'h0000_2000; m_dat_a[63:32] = 32'h1234_5678;
      m_sel_a[7:4] = 4'b0011; m_we_a = 2'b10; m_stb_a = 2'b10;
      step();
      m_adr_a[31:0] = 32'h0000_0300; m_stb_a = 2'b11;
      #1;
      chk("wr_grant", grant_a, 2'b10);
      chk("wr_s_adr", s_adr_a, 32'h0000_2000);
      chk("wr_s_dat", s_dat_a, 32'h1234_5678);
      chk("wr_s_sel", s_sel_a, 4'b0011);
      chk("wr_s_we", s_we_a, 1'b1);
      chk("wr_s_stb", s_stb_a, 1'b1);
      step(); #1;
      chk("wr_no_preempt", grant_a, 2'b10);
      step();
      s_ack_a = 1'b1; s_rdt_a = 32'h0000_0055;
      #1;
      chk("wr_ack_m1_only", ack_a, 2'b10);
      step();
      m_stb_a = 2'b01; m_we_a = 2'b00; s_ack_a = 1'b0;
      #1;
      chk("wr_idle_gap", grant_a, 2'b00);
      step(); #1;
      chk("m0_after_wr", grant_a, 2'b01);
      chk("m0_s_adr", s_adr_a, 32'h0000_0300);
      chk("m0_s_we", s_we_a, 1'b0);
      step();
      s_ack_a = 1'b1; s_rdt_a = 32'h0000_0077;
      #1;
      chk("m0_ack", ack_a, 2'b01);
      chk("m0_rdt", rdt_a, 32'h0000_0077);
      step();
      m_stb_a = 2'b00; s_ack_a = 1'b0; s_rdt_a = 32'h0;

      // Master 1 abandons its request without an ack.
      step();
      m_stb_a = 2'b10;
      step(); #1;
      chk("drop_grant", grant_a, 2'b10);
      step();
      m_stb_a = 2'b00;
      #1;
      chk("drop_s_stb", s_stb_a, 1'b0);
      chk("drop_no_ack", ack_a, 2'b00);
      step(); #1;
      chk("drop_idle", grant_a, 2'b00);

      // Master 0 against a silent slave.
      step();
      m_stb_a = 2'b01;
      step(); #1;
      chk("slow_grant", grant_a, 2'b01);
`ifdef SERVING_ARB_TIMEOUT_EN
      for (int k = 2; k <= 4; k++) begin
         step(); #1;
         chk("to_wait_pulse", to_a, 1'b0);
         chk("to_wait_ack", ack_a, 2'b00);
         chk("to_wait_stb", s_stb_a, 1'b1);
      end
      step(); #1;
      chk("to_ack", ack_a, 2'b01);
      chk("to_rdt", rdt_a, 32'h0);
      chk("to_pulse", to_a, 1'b1);
      chk("to_s_stb", s_stb_a, 1'b0);
      step(); #1;
      chk("to_pulse_end", to_a, 1'b0);
      chk("to_idle", grant_a, 2'b00);
      step(); #1;
      chk("to2_grant", grant_a, 2'b01);
      for (int k = 2; k <= 4; k++) begin
         step(); #1;
         chk("to2_wait", to_a, 1'b0);
      end
      step();
      s_ack_a = 1'b1; s_rdt_a = 32'h0000_BEEF;
      #1;
      chk("race_ack", ack_a, 2'b01);
      chk("race_rdt", rdt_a, 32'h0000_BEEF);
      chk("race_no_pulse", to_a, 1'b0);
`else
      for (int k = 2; k <= 7; k++) begin
         step(); #1;
         chk("wait_hold", grant_a, 2'b01);
         chk("wait_no_to", to_a, 1'b0);
      end
      step();
      s_ack_a = 1'b1; s_rdt_a = 32'h0000_BEEF;
      #1;
      chk("slow_ack", ack_a, 2'b01);
      chk("slow_rdt", rdt_a, 32'h0000_BEEF);
`endif
      step();
      m_stb_a = 2'b00; s_ack_a = 1'b0; s_rdt_a = 32'h0;

      // Leave master 1 as the last owner, then reset during a master-0 transaction.
      step();
      m_stb_a = 2'b10;
      step();
      s_ack_a = 1'b1;
      step();
      m_stb_a = 2'b11; s_ack_a = 1'b0;
      step(); #1;
      chk("pre_rst_grant", grant_a, 2'b01);
      s_ack_a = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_grant", grant_a, 2'b00);
      chk("rst_mid_s_stb", s_stb_a, 1'b0);
      chk("rst_mid_ack", ack_a, 2'b00);
      step(); #1;
      chk("rst_held_grant", grant_a, 2'b00);
      rst_n = 1'b1; s_ack_a = 1'b0;
      #1;
      chk("rst_rel_idle", grant_a, 2'b00);
      step(); #1;
      chk("rst_first_m0", grant_a, 2'b01);
      step();
      s_ack_a = 1'b1;
      #1;
      chk("rst_m0_ack", ack_a, 2'b01);
      step();
      m_stb_a = 2'b00; s_ack_a = 1'b0;

      // Three masters requesting continuously against an always-acking slave.
      step();
      s_ack_b = 1'b1; m_stb_b = 3'b111;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("rr3_grant", grant_b, exp_g[k]);
         chk("rr3_ack", ack_b, exp_g[k]);
         step(); #1;
      end
      m_stb_b = 3'b000; s_ack_b = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
